lvds_rx_align: RTL and testbench

- Receive-side counterpart of the LVDS output buffer path.
- Takes the single-ended serial bit stream from an LVDS input buffer, deserializes it MSB-first into WIDTH-bit words and finds the word boundary by bit-slipping against a known training pattern.
- Declares lock after LOCK_COUNT consecutive matching words, then passes data words to the core; flags pattern errors while training stays asserted.

---
 rtl/lvds_rx_align.sv | 154 +++++++++++++++
 tb/tb_lvds_rx_align.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_align.sv
// LVDS receive word aligner: MSB-first deserializer with bit-slip training and lock detection.
// Optional error counter output enabled by defining LVDS_RX_ERRCNT_EN.
module lvds_rx_align #(
   parameter int               WIDTH         = 8,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'h1B),
   parameter int               LOCK_COUNT    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sin,
   input  logic                     sin_valid,
   input  logic                     train_en,
   input  logic                     retrain,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic                     locked,
   output logic [$clog2(WIDTH)-1:0] slip_count,
   output logic                     err,
   output logic [1:0]               fsm_state
`ifdef LVDS_RX_ERRCNT_EN
   ,
   output logic [15:0]              err_count
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] word;
   logic [CW-1:0]    bit_cnt;
   logic             slip_pending;
   logic [3:0]       match_cnt;
   logic [3:0]       match_nxt;
   logic             word_done;
   logic             slip_req;
   logic             dv_nxt;
   logic             err_nxt;

   // A bit consumed by a pending slip never completes a word; that is what shifts the boundary.
   assign word      = {shreg[WIDTH-2:0], sin};
   assign word_done = sin_valid && !slip_pending && (bit_cnt == CW'(WIDTH - 1));
   assign locked    = (state == LOCKED);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEARCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      match_nxt = match_cnt;
      slip_req  = 1'b0;
      dv_nxt    = 1'b0;
      err_nxt   = 1'b0;
      if (retrain) begin
         state_nxt = SEARCH;
         match_nxt = 4'd0;
      end else if (word_done) begin
         case (state)
            SEARCH: begin
               if (train_en) begin
                  if (word == TRAIN_PATTERN) begin
                     match_nxt = 4'd1;
                     state_nxt = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
                  end else begin
                     slip_req = 1'b1;
                  end
               end
            end
            CONFIRM: begin
               if (train_en) begin
                  if (word == TRAIN_PATTERN) begin
                     match_nxt = match_cnt + 4'd1;
                     if (match_nxt == 4'(LOCK_COUNT)) begin
                        state_nxt = LOCKED;
                     end
                  end else begin
                     match_nxt = 4'd0;
                     slip_req  = 1'b1;
                     state_nxt = SEARCH;
                  end
               end
            end
            LOCKED: begin
               dv_nxt  = 1'b1;
               err_nxt = train_en && (word != TRAIN_PATTERN);
            end
            default: begin
               state_nxt = SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg        <= '0;
         bit_cnt      <= '0;
         slip_pending <= 1'b0;
         slip_count   <= '0;
         match_cnt    <= 4'd0;
         dout         <= '0;
         dout_valid   <= 1'b0;
         err          <= 1'b0;
      end else begin
         dout_valid <= dv_nxt;
         err        <= err_nxt;
         match_cnt  <= match_nxt;
         if (dv_nxt) begin
            dout <= word;
         end
         if (sin_valid) begin
            shreg <= word;
            if (slip_pending) begin
               slip_pending <= 1'b0;
            end else if (bit_cnt == CW'(WIDTH - 1)) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         // Slips are only requested on a non-slip bit, so this never collides with the clear above.
         if (slip_req) begin
            slip_pending <= 1'b1;
            slip_count   <= (slip_count == CW'(WIDTH - 1)) ? '0 : slip_count + 1'b1;
         end
      end
   end

`ifdef LVDS_RX_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= 16'd0;
      end else if (retrain) begin
         err_count <= 16'd0;
      end else if (err_nxt && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lvds_rx_align.sv
// Directed bench for lvds_rx_align: reset, aligned/misaligned training, lock errors,
// gapped data, retrain and mid-stream reset.
module tb_lvds_rx_align;

   localparam int         WIDTH   = 8;
   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_CONFIRM = 2'd1;
   localparam logic [1:0] S_LOCKED  = 2'd2;

   logic             clk;
   logic             rst_n;
   logic             sin;
   logic             sin_valid;
   logic             train_en;
   logic             retrain;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             locked;
   logic [2:0]       slip_count;
   logic             err;
   logic [1:0]       fsm_state;
`ifdef LVDS_RX_ERRCNT_EN
   logic [15:0]      err_count;
`endif

   int checks;
   int errors;
   int dv_cnt;
   int dv_base;

   lvds_rx_align #(
      .WIDTH(WIDTH),
      .TRAIN_PATTERN(8'h1B),
      .LOCK_COUNT(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sin(sin),
      .sin_valid(sin_valid),
      .train_en(train_en),
      .retrain(retrain),
      .dout(dout),
      .dout_valid(dout_valid),
      .locked(locked),
      .slip_count(slip_count),
      .err(err),
      .fsm_state(fsm_state)
`ifdef LVDS_RX_ERRCNT_EN
      ,
      .err_count(err_count)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dv_cnt <= 0;
      else if (dout_valid) dv_cnt <= dv_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      sin       = b;
      sin_valid = 1'b1;
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input bit gap);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         send_bit(w[i]);
         if (gap && i != 0) idle(1);
      end
   endtask

   task automatic pulse_retrain();
      retrain = 1'b1;
      @(posedge clk);
      #1;
      retrain = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      sin       = 1'b0;
      sin_valid = 1'b0;
      train_en  = 1'b0;
      retrain   = 1'b0;
      #1;
      chk("reset_dout", 32'(dout), 32'h0);
      chk("reset_dout_valid", 32'(dout_valid), 32'h0);
      chk("reset_locked", 32'(locked), 32'h0);
      chk("reset_slip_count", 32'(slip_count), 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_state", 32'(fsm_state), 32'(S_SEARCH));
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // aligned training: lock on 4th word
      train_en = 1'b1;
      for (int k = 0; k < 3; k++) send_word(8'h1B, 1'b0);
      chk("aligned_not_locked_3", 32'(locked), 32'h0);
      chk("aligned_state_confirm", 32'(fsm_state), 32'(S_CONFIRM));
      send_word(8'h1B, 1'b0);
      chk("aligned_locked_4", 32'(locked), 32'h1);
      chk("aligned_slip_count", 32'(slip_count), 32'h0);
      chk("aligned_no_dv_at_lock", 32'(dout_valid), 32'h0);
      chk("aligned_no_dv_before_lock", 32'(dv_cnt), 32'h0);
      send_word(8'h1B, 1'b0);
      chk("locked_dv", 32'(dout_valid), 32'h1);
      chk("locked_dout", 32'(dout), 32'h1B);
      chk("locked_no_err", 32'(err), 32'h0);

      // error while locked
      send_word(8'h1A, 1'b0);
      chk("err_pulse", 32'(err), 32'h1);
      chk("err_dout", 32'(dout), 32'h1A);
      chk("err_dv", 32'(dout_valid), 32'h1);
      chk("err_still_locked", 32'(locked), 32'h1);
`ifdef LVDS_RX_ERRCNT_EN
      chk("err_count_1", 32'(err_count), 32'h1);
`endif
      idle(1);
      chk("err_one_cycle", 32'(err), 32'h0);
      chk("dv_one_cycle", 32'(dout_valid), 32'h0);
      chk("dout_holds", 32'(dout), 32'h1A);

      // gapped data, training off
      train_en = 1'b0;
      dv_base  = dv_cnt;
      send_word(8'h3C, 1'b1);
      chk("gap_dv_3c", 32'(dout_valid), 32'h1);
      chk("gap_dout_3c", 32'(dout), 32'h3C);
      chk("gap_no_err_3c", 32'(err), 32'h0);
      idle(1);
      send_word(8'hC3, 1'b1);
      chk("gap_dv_c3", 32'(dout_valid), 32'h1);
      chk("gap_dout_c3", 32'(dout), 32'hC3);
      idle(1);
      chk("gap_two_pulses", 32'(dv_cnt - dv_base), 32'h2);

      // retrain, then misaligned training: 3 junk bits
      pulse_retrain();
      chk("retrain_unlocked", 32'(locked), 32'h0);
      chk("retrain_state", 32'(fsm_state), 32'(S_SEARCH));
`ifdef LVDS_RX_ERRCNT_EN
      chk("retrain_err_count", 32'(err_count), 32'h0);
`endif
      train_en = 1'b1;
      dv_base  = dv_cnt;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int k = 0; k < 7; k++) send_word(8'h1B, 1'b0);
      chk("mis_slip_count", 32'(slip_count), 32'h3);
      chk("mis_locked", 32'(locked), 32'h1);
      chk("mis_no_dv_in_search", 32'(dv_cnt - dv_base), 32'h0);
      send_word(8'h1B, 1'b0);
      chk("mis_first_dv", 32'(dout_valid), 32'h1);
      chk("mis_first_dout", 32'(dout), 32'h1B);

      // retrain mid-CONFIRM
      pulse_retrain();
      send_word(8'h1B, 1'b0);
      send_word(8'h1B, 1'b0);
      chk("confirm_state", 32'(fsm_state), 32'(S_CONFIRM));
      chk("confirm_unlocked", 32'(locked), 32'h0);
      pulse_retrain();
      chk("mid_retrain_state", 32'(fsm_state), 32'(S_SEARCH));
      chk("mid_retrain_locked", 32'(locked), 32'h0);
      chk("mid_retrain_slip", 32'(slip_count), 32'h3);

      // asynchronous reset mid-stream
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_dout", 32'(dout), 32'h0);
      chk("async_rst_slip", 32'(slip_count), 32'h0);
      chk("async_rst_locked", 32'(locked), 32'h0);
      chk("async_rst_state", 32'(fsm_state), 32'(S_SEARCH));
      chk("async_rst_dv", 32'(dout_valid), 32'h0);
      #2;
      rst_n = 1'b1;
      idle(1);

      // search holds with training off, then fresh relock
      train_en = 1'b0;
      send_word(8'hFF, 1'b0);
      chk("hold_no_slip", 32'(slip_count), 32'h0);
      chk("hold_state", 32'(fsm_state), 32'(S_SEARCH));
      train_en = 1'b1;
      for (int k = 0; k < 3; k++) send_word(8'h1B, 1'b0);
      chk("relock_not_yet", 32'(locked), 32'h0);
      send_word(8'h1B, 1'b0);
      chk("relock_locked", 32'(locked), 32'h1);
      chk("relock_slip", 32'(slip_count), 32'h0);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
